axis_pattern_gen: RTL

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

---
 rtl/axis_pattern_gen.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_pattern_gen.sv
// AXI-Stream test-pattern master: framed bursts of counter, LFSR, index or
// alternating-bit words with programmable frame length, inter-frame gap and run length.
module axis_pattern_gen #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned FSIZE_W = 16,
  parameter int unsigned GAP_W   = 16
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [FSIZE_W-1:0]  frame_size,
  input  logic [DATA_W/8-1:0] last_keep,
  input  logic [15:0]         frame_count,
  input  logic [GAP_W-1:0]    gap,
  output logic [DATA_W-1:0]   tdata,
  output logic [DATA_W/8-1:0] tkeep,
  output logic                tlast,
  output logic                tvalid,
  input  logic                tready,
  output logic                busy,
  output logic                done,
  output logic [31:0]         frames_sent
);

  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned LANES  = DATA_W / 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tdata_d;
  logic [KEEP_W-1:0]   tkeep_d;
  logic                tlast_d, tvalid_d, busy_d, done_d;
  logic [31:0]         frames_sent_d;

  logic [31:0]         cnt_q, cnt_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic                phase_q, phase_d;
  logic [FSIZE_W-1:0]  beat_q, beat_d;
  logic [15:0]         frame_q, frame_d;
  logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;

  logic [1:0]          mode_q, mode_d;
  logic [FSIZE_W-1:0]  fsize_q, fsize_d;
  logic [KEEP_W-1:0]   lkeep_q, lkeep_d;
  logic [15:0]         fcount_q, fcount_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic                xfer, start_frame, load;

  // Fibonacci LFSR, taps 32/22/2/1, shifting toward the MSB
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] pattern_word(
    input logic [1:0]  m,
    input logic [31:0] c,
    input logic [31:0] l,
    input logic [15:0] f,
    input logic [15:0] b,
    input logic        p
  );
    case (m)
      2'd0:    return c;
      2'd1:    return l;
      2'd2:    return {f, b};
      default: return p ? 32'hAAAA_AAAA : 32'h5555_5555;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      tdata       <= '0;
      tkeep       <= {KEEP_W{1'b1}};
      tlast       <= 1'b0;
      tvalid      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frames_sent <= '0;
      cnt_q       <= '0;
      lfsr_q      <= 32'hFFFF_FFFF;
      phase_q     <= 1'b0;
      beat_q      <= '0;
      frame_q     <= '0;
      gap_cnt_q   <= '0;
      mode_q      <= '0;
      fsize_q     <= '0;
      lkeep_q     <= '0;
      fcount_q    <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      tdata       <= tdata_d;
      tkeep       <= tkeep_d;
      tlast       <= tlast_d;
      tvalid      <= tvalid_d;
      busy        <= busy_d;
      done        <= done_d;
      frames_sent <= frames_sent_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      phase_q     <= phase_d;
      beat_q      <= beat_d;
      frame_q     <= frame_d;
      gap_cnt_q   <= gap_cnt_d;
      mode_q      <= mode_d;
      fsize_q     <= fsize_d;
      lkeep_q     <= lkeep_d;
      fcount_q    <= fcount_d;
      gap_q       <= gap_d;
    end
  end

  // Next-state and next-beat; a stalled beat (tvalid && !tready) leaves everything untouched
  always_comb begin
    state_d       = state_q;
    tdata_d       = tdata;
    tkeep_d       = tkeep;
    tlast_d       = tlast;
    tvalid_d      = tvalid;
    done_d        = 1'b0;
    frames_sent_d = frames_sent;
    cnt_d         = cnt_q;
    lfsr_d        = lfsr_q;
    phase_d       = phase_q;
    beat_d        = beat_q;
    frame_d       = frame_q;
    gap_cnt_d     = gap_cnt_q;
    mode_d        = mode_q;
    fsize_d       = fsize_q;
    lkeep_d       = lkeep_q;
    fcount_d      = fcount_q;
    gap_d         = gap_q;
    start_frame   = 1'b0;
    load          = 1'b0;
    xfer          = tvalid & tready;

    case (state_q)
      S_IDLE: begin
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        if (enable) begin
          fcount_d    = frame_count;
          frame_d     = '0;
          start_frame = 1'b1;
          state_d     = S_RUN;
        end
      end

      S_RUN: begin
        if (xfer) begin
          if (mode_q == 2'd0) cnt_d = cnt_q + 32'd1;
          if (mode_q == 2'd1) lfsr_d = lfsr_step(lfsr_q);
          phase_d = ~phase_q;
          if (tlast) begin
            frames_sent_d = frames_sent + 32'd1;
            if (fcount_q != 16'd0 && (frame_q + 16'd1) == fcount_q) begin
              done_d   = 1'b1;
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end else if (!enable) begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end else begin
              frame_d = frame_q + 16'd1;
              if (gap_q == '0) begin
                start_frame = 1'b1;
              end else begin
                state_d   = S_GAP;
                gap_cnt_d = gap_q;
                tvalid_d  = 1'b0;
                tlast_d   = 1'b0;
              end
            end
          end else begin
            beat_d = beat_q + FSIZE_W'(1);
            load   = 1'b1;
          end
        end
      end

      S_GAP: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          start_frame = 1'b1;
          state_d     = S_RUN;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Frame parameters are re-sampled only here, so mid-frame input changes are ignored
    if (start_frame) begin
      mode_d  = mode;
      fsize_d = frame_size;
      lkeep_d = last_keep;
      gap_d   = gap;
      beat_d  = '0;
      phase_d = 1'b0;
      load    = 1'b1;
    end

    if (load) begin
      tvalid_d = 1'b1;
      tlast_d  = (beat_d == fsize_d);
      tkeep_d  = tlast_d ? lkeep_d : {KEEP_W{1'b1}};
      tdata_d  = {LANES{pattern_word(mode_d, cnt_d, lfsr_d, frame_d, 16'(beat_d), phase_d)}};
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule
